// File: rtl/cpu_pkg.sv
// Constants shared by cpu_ctrl and cpu_datapath: ALU op codes, B-operand
// select codes and the derived data width.
package cpu_pkg;

    localparam int CPU_WIDTH          = 13;
    localparam int CPU_IWIDTH         = 5;
    localparam int CPU_REG_F_SEL_SIZE = 4;
    localparam int CPU_IN_B_SEL_SIZE  = 2;
    localparam int DW                 = CPU_WIDTH - CPU_IWIDTH;

    typedef enum logic [CPU_IWIDTH-2:0] {
        ALU_PASS = 4'd0,
        ALU_LD   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOT  = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_INC  = 4'd10,
        ALU_DEC  = 4'd11,
        ALU_ROL  = 4'd12,
        ALU_ROR  = 4'd13,
        ALU_ADC  = 4'd14,
        ALU_SBC  = 4'd15
    } alu_op_e;

    typedef enum logic [CPU_IN_B_SEL_SIZE-1:0] {
        B_IMM  = 2'd0,
        B_REG  = 2'd1,
        B_MEM  = 2'd2,
        B_ZERO = 2'd3
    } b_sel_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A, B, op and carry-in produce a DW-bit result, a
// carry/borrow-out and a flag saying whether this op defines the carry.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW_P      = DW,
    parameter bit USE_CARRY = 1'b0
) (
    input  logic [DW_P-1:0] a_i,
    input  logic [DW_P-1:0] b_i,
    input  alu_op_e         op_i,
    input  logic            c_i,
    output logic [DW_P-1:0] result_o,
    output logic            c_o,
    output logic            c_upd_o
);

    logic cin;
    logic rol_in;
    logic ror_in;

    // Without the carry feature ADC/SBC degrade to ADD/SUB and rotates wrap
    // the 8-bit value onto itself instead of going through C.
    assign cin    = USE_CARRY ? c_i : 1'b0;
    assign rol_in = USE_CARRY ? c_i : a_i[DW_P-1];
    assign ror_in = USE_CARRY ? c_i : a_i[0];

    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        result_o = a_i;
        c_o      = c_i;
        c_upd_o  = 1'b0;
        unique case (op_i)
            ALU_PASS: result_o = a_i;
            ALU_LD:   result_o = b_i;
            ALU_ADD: begin
                {c_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
                c_upd_o = 1'b1;
            end
            ALU_SUB: begin
                {c_o, result_o} = {1'b0, a_i} - {1'b0, b_i};
                c_upd_o = 1'b1;
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOT:  result_o = ~a_i;
            ALU_SHL: begin
                result_o = {a_i[DW_P-2:0], 1'b0};
                c_o      = a_i[DW_P-1];
                c_upd_o  = 1'b1;
            end
            ALU_SHR: begin
                result_o = {1'b0, a_i[DW_P-1:1]};
                c_o      = a_i[0];
                c_upd_o  = 1'b1;
            end
            ALU_INC: begin
                {c_o, result_o} = {1'b0, a_i} + {{DW_P{1'b0}}, 1'b1};
                c_upd_o = 1'b1;
            end
            ALU_DEC: begin
                {c_o, result_o} = {1'b0, a_i} - {{DW_P{1'b0}}, 1'b1};
                c_upd_o = 1'b1;
            end
            ALU_ROL: begin
                result_o = {a_i[DW_P-2:0], rol_in};
                c_o      = a_i[DW_P-1];
                c_upd_o  = 1'b1;
            end
            ALU_ROR: begin
                result_o = {ror_in, a_i[DW_P-1:1]};
                c_o      = a_i[0];
                c_upd_o  = 1'b1;
            end
            ALU_ADC: begin
                {c_o, result_o} = {1'b0, a_i} + {1'b0, b_i} + {{DW_P{1'b0}}, cin};
                c_upd_o = 1'b1;
            end
            ALU_SBC: begin
                {c_o, result_o} = {1'b0, a_i} - {1'b0, b_i} - {{DW_P{1'b0}}, cin};
                c_upd_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// One-cycle CPU execution datapath: ACC, 16-entry register file, data memory
// and ALU. Optional carry flag and port C when CPU_DATAPATH_CARRY_EN is defined.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH          = CPU_WIDTH,
    parameter int IWIDTH         = CPU_IWIDTH,
    parameter int REG_F_SEL_SIZE = CPU_REG_F_SEL_SIZE,
    parameter int IN_B_SEL_SIZE  = CPU_IN_B_SEL_SIZE
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [IWIDTH-2:0]         ALU_OUT,
    input  logic [WIDTH-IWIDTH-1:0]   IMM,
    input  logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
    input  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
    input  logic                      EN_REG_F,
    input  logic [WIDTH-IWIDTH-1:0]   D_MEM_ADDR,
    input  logic                      D_MEM_ADDR_MODE,
    input  logic                      EN_D_MEM,
    input  logic                      EN_ACC,
    output logic                      Z,
    output logic [WIDTH-IWIDTH-1:0]   ACC_OUT
`ifdef CPU_DATAPATH_CARRY_EN
    ,
    output logic                      C
`endif
);

    localparam int DATA_W   = WIDTH - IWIDTH;
    localparam int NUM_REGS = 2 ** REG_F_SEL_SIZE;
    localparam int MEM_SIZE = 2 ** DATA_W;
`ifdef CPU_DATAPATH_CARRY_EN
    localparam bit USE_CARRY = 1'b1;
`else
    localparam bit USE_CARRY = 1'b0;
`endif

    logic [DATA_W-1:0] acc_q, acc_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] reg_f_q [NUM_REGS];
    logic [DATA_W-1:0] d_mem_q [MEM_SIZE];

    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_c_out;
    logic              alu_c_upd;
    logic              carry_in;

    // The same address feeds the memory read and the write, and the indirect
    // form always uses the pre-edge ACC.
    assign mem_addr = D_MEM_ADDR_MODE ? acc_q : D_MEM_ADDR;

    always_comb begin
        operand_b = '0;
        case (b_sel_e'(IN_B_SEL))
            B_IMM:   operand_b = IMM;
            B_REG:   operand_b = reg_f_q[REG_F_SEL];
            B_MEM:   operand_b = d_mem_q[mem_addr];
            B_ZERO:  operand_b = '0;
            default: operand_b = '0;
        endcase
    end

    cpu_alu #(
        .DW_P      (DATA_W),
        .USE_CARRY (USE_CARRY)
    ) u_alu (
        .a_i      (acc_q),
        .b_i      (operand_b),
        .op_i     (alu_op_e'(ALU_OUT)),
        .c_i      (carry_in),
        .result_o (alu_result),
        .c_o      (alu_c_out),
        .c_upd_o  (alu_c_upd)
    );

    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        if (EN_ACC) begin
            acc_d = alu_result;
            z_d   = (alu_result == '0);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge ACC, which is what lets the simultaneous-enable cases work.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= '0;
            z_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_f_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            if (EN_REG_F) begin
                reg_f_q[REG_F_SEL] <= acc_q;
            end
        end
    end

    // NOTE: the data memory has no reset so it can map onto RAM; reset only
    // blocks the write.
    always_ff @(posedge CLK) begin
        if (!RST && EN_D_MEM) begin
            d_mem_q[mem_addr] <= acc_q;
        end
    end

`ifdef CPU_DATAPATH_CARRY_EN
    logic c_q, c_d;

    assign carry_in = c_q;

    always_comb begin
        c_d = c_q;
        if (EN_ACC && alu_c_upd) begin
            c_d = alu_c_out;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_q <= 1'b0;
        end else begin
            c_q <= c_d;
        end
    end

    assign C = c_q;
`else
    logic unused_carry;

    assign carry_in     = 1'b0;
    assign unused_carry = alu_c_out ^ alu_c_upd;
`endif

    assign Z       = z_q;
    assign ACC_OUT = acc_q;

endmodule
